// File: rtl/tick_sequencer.sv
// tick_sequencer: a step sequencer advanced by tick_lf strobes. Two raw
// buttons (start, stop) are synchronized, filtered into single press pulses
// and drive an IDLE/RUN/PAUSE/DONE state machine.
//
// Build option: define TICK_SEQUENCER_DEBOUNCE_EN to accept a button level
// only after DEBOUNCE consecutive identical samples taken on tick_mf. When
// it is undefined, the synchronized level is edge-detected every clk_in
// cycle and tick_mf / DEBOUNCE have no effect.
//
// Strobe semantics: tick_mf and tick_lf are one-cycle qualifiers sampled on
// posedge clk_in; there is no back-pressure. A press pulse is high for exactly
// one cycle per accepted 0->1 button transition and is consumed by the state
// machine on the following edge.
module tick_sequencer #(
  parameter int STEPS      = 8,
  parameter int STEP_TICKS = 1,
  parameter int DEBOUNCE   = 4
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     tick_mf,
  input  logic                     tick_lf,
  input  logic                     btn_start,
  input  logic                     btn_stop,
  input  logic                     mode_loop,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic [1:0]               state,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(STEPS);
  localparam logic [IW-1:0] LAST_STEP = IW'(STEPS - 1);
  localparam logic [7:0]    LAST_TICK = 8'(STEP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit 0 = start, bit 1 = stop throughout the button path.
  logic [1:0] btn_raw;
  assign btn_raw = {btn_stop, btn_start};

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] vld_q;     // fills with ones once sync2_q holds real samples
  logic [1:0] lvl_q;     // accepted button level
  logic [1:0] lvl_d;
  logic [1:0] press_q;   // one-cycle press pulses
  logic [1:0] press_d;

  // Two-flop synchronizer plus a marker that the pipeline holds post-reset data.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

`ifdef TICK_SEQUENCER_DEBOUNCE_EN
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);

  logic [1:0][3:0] cnt_q;
  logic [1:0][3:0] cnt_d;

  // Count consecutive tick_mf samples that differ from the accepted level;
  // accept the new level on the DEBOUNCE-th one, pulsing only for a rise.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    press_d = '0;
    if (vld_q[1] && tick_mf) begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          lvl_d[i]   = sync2_q[i];
          cnt_d[i]   = '0;
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end
`else
  logic       unused_tick_mf;
  logic [3:0] unused_debounce;
  assign unused_tick_mf  = tick_mf;
  assign unused_debounce = 4'(DEBOUNCE);

  // Plain rising-edge detect on the synchronized level, every cycle.
  always_comb begin
    lvl_d   = lvl_q;
    press_d = '0;
    if (vld_q[1]) begin
      lvl_d   = sync2_q;
      press_d = sync2_q & ~lvl_q;
    end
  end
`endif

  // Filter registers. The accepted level resets high so a button held
  // through reset must first be seen low before it can press again.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      lvl_q   <= 2'b11;
      press_q <= '0;
`ifdef TICK_SEQUENCER_DEBOUNCE_EN
      cnt_q   <= '0;
`endif
    end else begin
      lvl_q   <= lvl_d;
      press_q <= press_d;
`ifdef TICK_SEQUENCER_DEBOUNCE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  logic press_start;
  logic press_stop;
  assign press_start = press_q[0];
  assign press_stop  = press_q[1];

  state_e        state_q;
  state_e        state_d;
  logic [IW-1:0] step_q;
  logic [IW-1:0] step_d;
  logic [7:0]    tcnt_q;
  logic [7:0]    tcnt_d;
  logic          busy_q;
  logic          done_q;
  logic          done_d;

  // Next-state logic; a stop press always wins over a start press.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!press_stop && press_start) begin
          state_d = ST_RUN;
          step_d  = '0;
          tcnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (press_stop) begin
          // The tick of this cycle, if any, is deliberately dropped.
          state_d = ST_PAUSE;
        end else if (tick_lf) begin
          if (tcnt_q == LAST_TICK) begin
            tcnt_d = '0;
            if (step_q == LAST_STEP) begin
              step_d = '0;
              if (!mode_loop) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else begin
              step_d = step_q + IW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      ST_PAUSE: begin
        if (press_stop) begin
          state_d = ST_IDLE;
          step_d  = '0;
          tcnt_d  = '0;
        end else if (press_start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (press_stop) begin
          state_d = ST_IDLE;
          step_d  = '0;
          tcnt_d  = '0;
        end else if (press_start) begin
          state_d = ST_RUN;
          step_d  = '0;
          tcnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      tcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tcnt_q  <= tcnt_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= done_d;
    end
  end

  assign state    = state_q;
  assign step_idx = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Testbench for tick_sequencer: directed button/tick scenarios, a behavioural
// model that tracks progress as a single elapsed-tick position, a per-cycle
// scoreboard, and hand-computed checkpoints.
module tb_tick_sequencer;

  localparam int STEPS      = 4;
  localparam int STEP_TICKS = 2;
  localparam int DEBOUNCE   = 2;
  localparam int IW         = $clog2(STEPS);
  localparam int W          = 4 + IW;

`ifdef TICK_SEQUENCER_DEBOUNCE_EN
  localparam int ACT      = 5;        // cycle index at which a press reaches the FSM
  localparam int DEB_EFF  = DEBOUNCE;
  localparam bit MF_GATED = 1'b1;
`else
  localparam int ACT      = 3;
  localparam int DEB_EFF  = 1;
  localparam bit MF_GATED = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk_in    = 1'b0;
  logic          rst       = 1'b1;
  logic          tick_mf   = 1'b0;
  logic          tick_lf   = 1'b0;
  logic          btn_start = 1'b0;
  logic          btn_stop  = 1'b0;
  logic          mode_loop = 1'b0;
  logic [IW-1:0] step_idx;
  logic [1:0]    state;
  logic          busy;
  logic          done;

  always #5 clk_in = ~clk_in;

  tick_sequencer #(
    .STEPS      (STEPS),
    .STEP_TICKS (STEP_TICKS),
    .DEBOUNCE   (DEBOUNCE)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .tick_mf   (tick_mf),
    .tick_lf   (tick_lf),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .mode_loop (mode_loop),
    .step_idx  (step_idx),
    .state     (state),
    .busy      (busy),
    .done      (done)
  );

  int         total     = 0;
  int         bad       = 0;
  int         done_seen = 0;
  bit         chk_en    = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Progress is one position counter (ticks elapsed in the sequence);
  // step_idx is simply position / STEP_TICKS.
  logic [1:0] m_d1, m_d2;
  int         m_age;
  logic [1:0] m_acc;
  int         m_run[2];
  logic [1:0] m_pend;
  int         m_state;
  int         m_pos;
  bit         m_done;

  always @(posedge clk_in) begin
    logic [1:0] raw;
    logic [1:0] new_pend;
    bit st, sp;
    raw = {btn_stop, btn_start};
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_age = 0; m_acc = 2'b11;
      m_run[0] = 0; m_run[1] = 0; m_pend = '0;
      m_state = 0; m_pos = 0; m_done = 1'b0;
    end else begin
      st = m_pend[0];
      sp = m_pend[1];
      m_done = 1'b0;
      case (m_state)
        0: if (!sp && st) begin m_state = 1; m_pos = 0; end
        1: begin
          if (sp) m_state = 2;
          else if (tick_lf) begin
            m_pos++;
            if (m_pos == STEPS * STEP_TICKS) begin
              m_pos = 0;
              if (!mode_loop) begin m_state = 3; m_done = 1'b1; end
            end
          end
        end
        2: begin
          if (sp) begin m_state = 0; m_pos = 0; end
          else if (st) m_state = 1;
        end
        default: begin
          if (sp) begin m_state = 0; m_pos = 0; end
          else if (st) begin m_state = 1; m_pos = 0; end
        end
      endcase
      new_pend = '0;
      if (m_age >= 2 && (!MF_GATED || tick_mf)) begin
        for (int i = 0; i < 2; i++) begin
          if (m_d2[i] == m_acc[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] >= DEB_EFF) begin
              m_acc[i]    = m_d2[i];
              m_run[i]    = 0;
              new_pend[i] = m_d2[i];
            end
          end
        end
      end
      m_pend = new_pend;
      m_d2 = m_d1;
      m_d1 = raw;
      if (m_age < 2) m_age++;
    end
    if (chk_en)
      exp_q.push_back({2'(m_state), IW'(m_pos / STEP_TICKS), (m_state == 1), m_done});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_in) begin
    logic [W-1:0] got_v;
    logic [W-1:0] exp_v;
    if (chk_en) begin
      got_v = {state, step_idx, busy, done};
      if (done === 1'b1) done_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got=%0h expected=<entry> at %0t", got_v, $time);
      end else begin
        exp_v = exp_q.pop_front();
        check("cycle_outputs", got_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic lf_pulse();
    tick_lf = 1'b1;
    @(negedge clk_in);
    tick_lf = 1'b0;
    @(negedge clk_in);
  endtask

  // Hold the buttons for 8 cycles (3 tick_mf), optionally raising tick_lf at
  // cycle lf_at, then release for 8 cycles so the low level is accepted.
  task automatic press(input bit s, input bit p, input int lf_at);
    btn_start = s;
    btn_stop  = p;
    for (int c = 0; c < 8; c++) begin
      tick_mf = (c == 2 || c == 4 || c == 6);
      tick_lf = (c == lf_at);
      @(negedge clk_in);
    end
    tick_mf   = 1'b0;
    tick_lf   = 1'b0;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick_mf = (c == 2 || c == 4 || c == 6);
      @(negedge clk_in);
    end
    tick_mf = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int ds;
    chk_en = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_state", state, 0);
    check("rst_step", step_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    press(1'b0, 1'b0, -1);

    // start held for 3 tick_mf: run begins one cycle after acceptance
    btn_start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick_mf = (c == 2 || c == 4 || c == 6);
      @(negedge clk_in);
      if (c == ACT - 1) check("start_pre_accept", state, 0);
      if (c == ACT) begin
        check("start_run_state", state, 1);
        check("start_busy", busy, 1);
      end
    end
    tick_mf   = 1'b0;
    btn_start = 1'b0;
    press(1'b0, 1'b0, -1);
    check("run_step0", step_idx, 0);

    // one-shot run to DONE
    mode_loop = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      lf_pulse();
      if (t % 2 == 0) check($sformatf("step_after_%0d", t), step_idx, t / 2);
    end
    tick_lf = 1'b1;
    @(negedge clk_in);
    tick_lf = 1'b0;
    check("done_pulse", done, 1);
    check("done_state", state, 3);
    check("done_step", step_idx, 0);
    check("done_busy", busy, 0);
    @(negedge clk_in);
    check("done_one_cycle", done, 0);
    lf_pulse();
    check("done_hold", state, 3);

    // looping run: 10 ticks wrap without a done pulse
    press(1'b1, 1'b0, -1);
    check("restart_state", state, 1);
    check("restart_step", step_idx, 0);
    mode_loop = 1'b1;
    ds = done_seen;
    repeat (10) lf_pulse();
    check("loop_state", state, 1);
    check("loop_step", step_idx, 1);
    check("loop_no_done", done_seen - ds, 0);

    // pause / resume keeps position
    repeat (3) lf_pulse();
    check("pre_stop_step", step_idx, 2);
    press(1'b0, 1'b1, -1);
    check("pause_state", state, 2);
    check("pause_busy", busy, 0);
    repeat (3) lf_pulse();
    check("pause_step_hold", step_idx, 2);
    press(1'b1, 1'b0, -1);
    check("resume_state", state, 1);
    check("resume_step", step_idx, 2);
    lf_pulse();
    check("resume_advance", step_idx, 3);

    // stop coinciding with a tick: the tick is not counted
    press(1'b0, 1'b1, ACT);
    check("stop_tick_state", state, 2);
    check("stop_tick_step", step_idx, 3);
    press(1'b1, 1'b0, -1);
    lf_pulse();
    check("stop_tick_uncounted", step_idx, 3);
    lf_pulse();
    check("wrap_step", step_idx, 0);
    check("wrap_state", state, 1);

    // start in RUN is ignored, a coinciding tick still counts
    press(1'b1, 1'b0, ACT);
    check("start_in_run_state", state, 1);
    lf_pulse();
    check("start_in_run_step", step_idx, 1);

    // simultaneous start+stop resolves as stop
    press(1'b0, 1'b1, -1);
    check("pause2_state", state, 2);
    press(1'b1, 1'b1, -1);
    check("both_state", state, 0);
    check("both_step", step_idx, 0);
    press(1'b1, 1'b1, -1);
    check("both_idle_state", state, 0);

    // reset mid-run with start held
    press(1'b1, 1'b0, -1);
    mode_loop = 1'b0;
    repeat (6) lf_pulse();
    check("pre_rst_step", step_idx, 3);
    check("pre_rst_state", state, 1);
    ds = done_seen;
    btn_start = 1'b1;
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    check("rst_run_state", state, 0);
    check("rst_run_step", step_idx, 0);
    check("rst_run_busy", busy, 0);
    check("rst_run_done", done, 0);
    for (int c = 0; c < 16; c++) begin
      tick_mf = (c % 2 == 1);
      @(negedge clk_in);
    end
    tick_mf = 1'b0;
    check("held_no_restart", state, 0);
    check("rst_no_done", done_seen - ds, 0);

    // release re-arms; then DONE + stop returns to IDLE
    press(1'b0, 1'b0, -1);
    press(1'b1, 1'b0, -1);
    check("rearm_state", state, 1);
    repeat (8) lf_pulse();
    check("done2_state", state, 3);
    press(1'b0, 1'b1, -1);
    check("done_stop_state", state, 0);
    check("done_stop_step", step_idx, 0);

    repeat (2) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
